// File: rtl/ctrl_pkg.sv
// Shared opcode and ALU-op encodings for the decode stage, ALU control and hazard unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int ALU_OP_WIDTH = 3;

    localparam logic [2:0] ALU_OP_ADD    = 3'b000;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
    localparam logic [2:0] ALU_OP_IALU   = 3'b011;
    localparam logic [2:0] ALU_OP_PASSB  = 3'b100;
    localparam logic [2:0] ALU_OP_AUIPC  = 3'b101;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    alu_src;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    branch;
        logic                    jump;
        logic                    link;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I opcode decode into the control bundle plus operand-use flags.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal_dec
);

    always_comb begin
        ctrl        = '0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        illegal_dec = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.alu_op    = ALU_OP_RTYPE;
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                uses_rs1        = 1'b1;
            end
            OP_IMM: begin
                ctrl.alu_op    = ALU_OP_IALU;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALU_OP_BRANCH;
                ctrl.branch = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.link      = 1'b1;
            end
            OP_JALR: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.link      = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op    = ALU_OP_PASSB;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alu_op    = ALU_OP_AUIPC;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: illegal_dec = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID stage: decode, load-use hazard bubble, flush, and the registered ID->EX control bundle.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALU_OP_W  = 3,
    parameter int CNT_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         instr,
    output logic                id_ready,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_mem_to_reg,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic                ex_link,
    output logic [REG_AW-1:0]   ex_rs1,
    output logic [REG_AW-1:0]   ex_rs2,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                illegal,
    output logic [CNT_W-1:0]    stall_cnt
);

    ctrl_t             dec;
    ctrl_t             ex_ctrl;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              illegal_dec;
    logic              advance;
    logic              hazard;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              unused_bits;

    assign rs1         = instr[15 +: REG_AW];
    assign rs2         = instr[20 +: REG_AW];
    assign rd          = instr[7 +: REG_AW];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    ctrl_decode u_decode (
        .opcode      (instr[6:0]),
        .ctrl        (dec),
        .uses_rs1    (uses_rs1),
        .uses_rs2    (uses_rs2),
        .illegal_dec (illegal_dec)
    );

    assign advance = !ex_valid || ex_ready;

    generate
        if (HAZARD_EN) begin : g_hazard
            // Only a load in EX can create a use the forwarding path cannot cover.
            assign hazard = if_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
                            ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    assign id_ready = advance && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                ex_valid <= 1'b0;
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + CNT_W'(1);
            end else if (if_valid) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= dec;
                ex_rs1   <= rs1;
                ex_rs2   <= rs2;
                ex_rd    <= rd;
                if (illegal_dec)
                    illegal <= 1'b1;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign ex_alu_op     = ALU_OP_W'(ex_ctrl.alu_op);
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_link       = ex_ctrl.link;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed plus randomized bench for pipelined_control_unit against a slot-level reference model.
module tb_pipelined_control_unit;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                if_valid = 1'b0;
    logic [31:0]         instr = '0;
    logic                id_ready;
    logic                flush = 1'b0;
    logic                ex_ready = 1'b1;
    logic                ex_valid;
    logic [2:0]          ex_alu_op;
    logic                ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read;
    logic                ex_mem_write, ex_branch, ex_jump, ex_link;
    logic [4:0]          ex_rs1, ex_rs2, ex_rd;
    logic                illegal;
    logic [TB_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipelined_control_unit #(.REG_AW(5), .ALU_OP_W(3), .CNT_W(TB_CNT_W), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .id_ready(id_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_link(ex_link), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what sits in the EX slot, the sticky flag and the bubble count.
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic        m_illegal = 1'b0;
    int          m_cnt = 0;
    logic        last_acc;

    // {alu_op[2:0], alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, link}
    function automatic logic [10:0] exp_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return {3'b010, 8'b00100000};
            7'b0000011: return {3'b000, 8'b11110000};
            7'b0010011: return {3'b011, 8'b10100000};
            7'b0100011: return {3'b000, 8'b10001000};
            7'b1100011: return {3'b001, 8'b00000100};
            7'b1101111: return {3'b000, 8'b00100011};
            7'b1100111: return {3'b000, 8'b10100011};
            7'b0110111: return {3'b100, 8'b10100000};
            7'b0010111: return {3'b101, 8'b10100000};
            default:    return 11'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, op};
    endfunction

    // True when the instruction on the fetch port depends on a load currently in EX.
    function automatic logic model_hazard();
        logic [10:0] c;
        logic [4:0]  lrd;
        c   = exp_ctrl(m_instr[6:0]);
        lrd = m_instr[11:7];
        return if_valid && m_valid && c[4] && (lrd != 5'd0) &&
               ((reads_rs1(instr[6:0]) && instr[19:15] == lrd) ||
                (reads_rs2(instr[6:0]) && instr[24:20] == lrd));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [10:0] c;
        chk("ex_valid", ex_valid, m_valid);
        chk("illegal", illegal, m_illegal);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
            c = exp_ctrl(m_instr[6:0]);
            chk("ctrl", {ex_alu_op, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                         ex_mem_write, ex_branch, ex_jump, ex_link}, c);
            chk("regs", {ex_rs1, ex_rs2, ex_rd}, {m_instr[19:15], m_instr[24:20], m_instr[11:7]});
        end
    endtask

    // One cycle: drive at negedge, check id_ready, advance model at posedge, check regs at negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic er,
                        input logic fl, input logic r);
        logic adv, haz, rdy;
        if_valid = v; instr = ins; ex_ready = er; flush = fl; rst = r;
        #1;
        adv = !m_valid || er;
        haz = model_hazard();
        rdy = adv && !haz && !fl;
        if (!r) chk("id_ready", id_ready, rdy);
        last_acc = !r && rdy && v;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_instr = '0; m_illegal = 1'b0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (adv) begin
            if (haz) begin
                m_valid = 1'b0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (v) begin
                m_valid = 1'b1;
                m_instr = ins;
                if (!is_legal(ins[6:0])) m_illegal = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_fields", {ex_valid, ex_alu_op, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_link,
                           ex_rs1, ex_rs2, ex_rd, illegal, stall_cnt}, 32'h0);
        chk("rst_id_ready", id_ready, 1'b1);
    endtask

    // Present an instruction until it is accepted, with a bounded number of tries.
    task automatic issue(input logic [31:0] ins, output int tries);
        tries = 0;
        do begin
            step(1'b1, ins, 1'b1, 1'b0, 1'b0);
            tries++;
        end while (!last_acc && tries < 8);
        chk("issue_timeout", last_acc, 1'b1);
    endtask

    logic [6:0] ops [10];
    int         t;

    initial begin
        ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        @(negedge clk);

        // 1: nine legal opcodes back to back
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, mk(ops[i], 5'(10 + i), 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
            chk("b2b_acc", last_acc, 1'b1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // 2: load-use with x5, then the same with rd=x0
        do_reset();
        issue(mk(7'b0000011, 5'd5, 5'd1, 5'd0), t);
        issue(mk(7'b0110011, 5'd6, 5'd5, 5'd2), t);
        chk("lu_tries", t, 2);
        chk("lu_cnt", stall_cnt, 2'd1);
        issue(mk(7'b0000011, 5'd0, 5'd1, 5'd0), t);
        issue(mk(7'b0110011, 5'd6, 5'd0, 5'd2), t);
        chk("x0_tries", t, 1);

        // 3: store consuming the load gets a bubble, LUI does not
        issue(mk(7'b0000011, 5'd5, 5'd1, 5'd0), t);
        issue(mk(7'b0100011, 5'd0, 5'd5, 5'd5), t);
        chk("sw_tries", t, 2);
        issue(mk(7'b0000011, 5'd5, 5'd1, 5'd0), t);
        issue(mk(7'b0110111, 5'd5, 5'd5, 5'd5), t);
        chk("lui_tries", t, 1);

        // 4: EX backpressure holds the bundle
        issue(mk(7'b0010011, 5'd7, 5'd3, 5'd0), t);
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(7'b1100011, 5'd0, 5'd4, 5'd5), 1'b0, 1'b0, 1'b0);
        chk("hold_rd", ex_rd, 5'd7);
        step(1'b1, mk(7'b1100011, 5'd0, 5'd4, 5'd5), 1'b1, 1'b0, 1'b0);
        chk("release_acc", last_acc, 1'b1);

        // 5: flush with a new instr, and flush during a hazard
        step(1'b1, mk(7'b1101111, 5'd1, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        chk("flush_acc", last_acc, 1'b0);
        issue(mk(7'b0000011, 5'd5, 5'd1, 5'd0), t);
        step(1'b1, mk(7'b0110011, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1, 1'b0);
        chk("flush_haz_cnt", stall_cnt, 2'd2);

        // 6: illegal opcode is sticky, counter saturates, reset mid-run clears everything
        issue(32'h0000007F, t);
        chk("ill_ctrl", {ex_alu_op, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                         ex_mem_write, ex_branch, ex_jump, ex_link}, 11'h0);
        issue(mk(7'b0010011, 5'd8, 5'd1, 5'd0), t);
        chk("ill_sticky", illegal, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(mk(7'b0000011, 5'd1, 5'd2, 5'd0), t);
            issue(mk(7'b0110011, 5'd3, 5'd1, 5'd1), t);
        end
        chk("sat_cnt", stall_cnt, 2'd3);
        step(1'b1, mk(7'b0000011, 5'd9, 5'd2, 5'd0), 1'b1, 1'b0, 1'b0);
        do_reset();

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step(1'b1 & ($urandom_range(0, 3) != 0),
                 mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
